// File: rtl/note_render_pkg.sv
// Shared colour constants and FSM encoding for the note lane renderer.
package note_render_pkg;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] BLUE   = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/note_lane_renderer_if.sv
// Frame request / pixel stream bundle between the note lane renderer and its neighbours.
interface note_lane_renderer_if #(
  parameter int NUM_SLOTS = 10,
  parameter int X_W       = 8,
  parameter int Y_W       = 7
);
  logic                 start;
  logic                 clear;
  logic [NUM_SLOTS-1:0] red_sequence;
  logic [NUM_SLOTS-1:0] yellow_sequence;
  logic                 busy;
  logic                 done;
  logic [X_W-1:0]       x;
  logic [Y_W-1:0]       y;
  logic [2:0]           colour;
  logic                 plot;

  modport master (
    output start, clear, red_sequence, yellow_sequence,
    input  busy, done, x, y, colour, plot
  );

  modport slave (
    input  start, clear, red_sequence, yellow_sequence,
    output busy, done, x, y, colour, plot
  );
endinterface

// File: rtl/square_pixel_counter.sv
// dx/dy raster counter for one SQ_SIZE x SQ_SIZE square; exposes next values so
// the caller can register outputs in the same cycle the counter moves.
module square_pixel_counter #(
  parameter  int SQ_SIZE = 4,
  localparam int CW      = (SQ_SIZE > 1) ? $clog2(SQ_SIZE) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic [CW-1:0] o_dx_nxt,
  output logic [CW-1:0] o_dy_nxt,
  output logic          o_last_pixel
);

  localparam logic [CW-1:0] LAST = CW'(SQ_SIZE - 1);

  logic [CW-1:0] r_dx;
  logic [CW-1:0] r_dy;

  assign o_last_pixel = (r_dx == LAST) && (r_dy == LAST);

  always_comb begin
    o_dx_nxt = r_dx;
    o_dy_nxt = r_dy;
    if (i_clr) begin
      o_dx_nxt = '0;
      o_dy_nxt = '0;
    end else if (i_adv) begin
      if (r_dx == LAST) begin
        o_dx_nxt = '0;
        o_dy_nxt = (r_dy == LAST) ? '0 : r_dy + 1'b1;
      end else begin
        o_dx_nxt = r_dx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dx <= '0;
      r_dy <= '0;
    end else begin
      r_dx <= o_dx_nxt;
      r_dy <= o_dy_nxt;
    end
  end

endmodule

// File: rtl/note_lane_renderer.sv
// Note lane renderer: on start, snapshots the note sequences and plots every pixel
// of NUM_SLOTS squares, one per clock, each slot red, yellow or black.
module note_lane_renderer
  import note_render_pkg::*;
#(
  parameter int NUM_SLOTS = 10,
  parameter int SQ_SIZE   = 4,
  parameter int X_ORIGIN  = 10,
  parameter int X_PITCH   = 10,
  parameter int Y_ROW     = 112,
  parameter int X_W       = 8,
  parameter int Y_W       = 7
) (
  input logic                 clk,
  input logic                 resetn,
  note_lane_renderer_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start; outputs held at zero
  // DRAW  | one pixel per cycle, plot high
  // DONE  | one-cycle done pulse, busy still high

  localparam int CW = (SQ_SIZE > 1) ? $clog2(SQ_SIZE) : 1;
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  if (X_ORIGIN + (NUM_SLOTS - 1) * X_PITCH + SQ_SIZE - 1 >= (1 << X_W)) begin : g_x_range
    $error("note_lane_renderer: last slot column does not fit in X_W bits");
  end
  if (Y_ROW + SQ_SIZE - 1 >= (1 << Y_W)) begin : g_y_range
    $error("note_lane_renderer: square rows do not fit in Y_W bits");
  end

  state_t               r_state, w_state_nxt;
  logic [NUM_SLOTS-1:0] r_red, r_yellow, w_red_src, w_yellow_src;
  logic                 r_clear, w_clear_src;
  logic [SW-1:0]        r_slot, w_slot_nxt;
  logic [X_W-1:0]       r_xoff, w_xoff_nxt;
  logic [X_W-1:0]       r_x, w_x_nxt;
  logic [Y_W-1:0]       r_y, w_y_nxt;
  logic [2:0]           r_colour, w_colour_nxt;
  logic                 r_busy, r_done, r_plot;
  logic                 w_busy_nxt, w_done_nxt, w_plot_nxt;
  logic                 w_clr, w_adv, w_last_pixel, w_frame_last;
  logic [CW-1:0]        w_dx_nxt, w_dy_nxt;

  square_pixel_counter #(.SQ_SIZE(SQ_SIZE)) u_pix (
    .clk          (clk),
    .resetn       (resetn),
    .i_clr        (w_clr),
    .i_adv        (w_adv),
    .o_dx_nxt     (w_dx_nxt),
    .o_dy_nxt     (w_dy_nxt),
    .o_last_pixel (w_last_pixel)
  );

  assign w_frame_last = w_last_pixel && (r_slot == SW'(NUM_SLOTS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_adv       = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_plot_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_DRAW;
          w_clr       = 1'b1;
          w_busy_nxt  = 1'b1;
          w_plot_nxt  = 1'b1;
        end
      end
      S_DRAW: begin
        w_busy_nxt = 1'b1;
        if (w_frame_last) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_adv      = 1'b1;
          w_plot_nxt = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // On the accepting edge the snapshot is not loaded yet, so pixel 0 reads the inputs.
  always_comb begin
    w_red_src    = w_clr ? bus.red_sequence    : r_red;
    w_yellow_src = w_clr ? bus.yellow_sequence : r_yellow;
    w_clear_src  = w_clr ? bus.clear           : r_clear;

    w_slot_nxt = r_slot;
    w_xoff_nxt = r_xoff;
    if (w_clr) begin
      w_slot_nxt = '0;
      w_xoff_nxt = '0;
    end else if (w_adv && w_last_pixel) begin
      w_slot_nxt = r_slot + 1'b1;
      w_xoff_nxt = r_xoff + X_W'(X_PITCH);
    end

    w_x_nxt      = '0;
    w_y_nxt      = '0;
    w_colour_nxt = BLACK;
    if (w_plot_nxt) begin
      w_x_nxt = X_W'(X_ORIGIN) + w_xoff_nxt + X_W'(w_dx_nxt);
      w_y_nxt = Y_W'(Y_ROW) + Y_W'(w_dy_nxt);
      if (w_clear_src)                  w_colour_nxt = BLACK;
      else if (w_red_src[w_slot_nxt])   w_colour_nxt = RED;
      else if (w_yellow_src[w_slot_nxt]) w_colour_nxt = YELLOW;
      else                              w_colour_nxt = BLACK;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_red    <= '0;
      r_yellow <= '0;
      r_clear  <= 1'b0;
      r_slot   <= '0;
      r_xoff   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_plot   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= BLACK;
    end else begin
      if (w_clr) begin
        r_red    <= bus.red_sequence;
        r_yellow <= bus.yellow_sequence;
        r_clear  <= bus.clear;
      end
      r_slot   <= w_slot_nxt;
      r_xoff   <= w_xoff_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_plot   <= w_plot_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_colour <= w_colour_nxt;
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.plot   = r_plot;
  assign bus.x      = r_x;
  assign bus.y      = r_y;
  assign bus.colour = r_colour;

endmodule
